uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the UART transmitter, consuming its line output and recovering 8N1 frames (LSB first, one start bit, eight data bits, one stop bit) at CLKS_PER_BIT clocks per bit. It synchronises the asynchronous line and samples each bit at its midpoint. It presents each received byte with a single-cycle valid strobe and flags framing errors.

## Interface
- CLKS_PER_BIT, 8, clocks per serial bit; legal range 4..255; must equal the transmitter's value.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- uart_in  input  1  serial line, asynchronous to clk, idles high.
- data_byte  output  8  last correctly framed byte; holds until the next good frame.
- data_valid  output  1  one-cycle pulse; data_byte is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.
- lineactive  output  1  high from start-bit detection until the frame ends (state returns to IDLE or WAIT_HIGH).

## Operation
- Two-flop synchronizer on uart_in; both flops reset to 1. All decisions use the synchronised line rx_s.
- 8-bit clock_counter and 3-bit data_index. H = (CLKS_PER_BIT-1)/2, using integer division.
- States:
  - IDLE: counter and index are 0. rx_s==0 -> START_BIT, lineactive<=1.
  - START_BIT: counter increments. At counter==H, sample rx_s:
    - 0: counter<=0 -> DATA_BITS.
    - 1: false start, lineactive<=0 -> IDLE.
  - DATA_BITS: counter increments. At counter==CLKS_PER_BIT-1: shift_reg[data_index]<=rx_s, counter<=0.
    - index<7: index+1.
    - index==7: index<=0 -> STOP_BIT, or PARITY_BIT when configured.
  - PARITY_BIT (macro only): at counter==CLKS_PER_BIT-1, store the parity mismatch, counter<=0 -> STOP_BIT.
  - STOP_BIT: at counter==CLKS_PER_BIT-1, sample rx_s and set lineactive<=0:
    - 1: data_byte<=shift_reg, data_valid<=1, parity_err<=stored mismatch -> IDLE.
    - 0: frame_err<=1, data_byte unchanged -> WAIT_HIGH.
  - WAIT_HIGH: wait for rx_s==1 -> IDLE. This prevents a held-low (break) line from re-triggering reception.
  - Undefined encodings -> IDLE.
- data_valid, frame_err and parity_err are never high for more than one cycle.
- data_valid and frame_err are mutually exclusive.

## Timing
- Reset values:
  - data_byte=0; data_valid, frame_err, parity_err and lineactive = 0.
  - State IDLE, counters 0, synchronizer flops 1.
- Cycle 0 is the first rising edge at which uart_in=0 is captured by sync flop 1.
  - rx_s is low at cycle 2; START_BIT is entered at cycle 3.
  - Start bit is sampled at cycle 3+H; DATA_BITS is entered at 4+H.
  - Data bit k is sampled at 4+H+k*CLKS_PER_BIT+CLKS_PER_BIT-1.
  - data_valid or frame_err is high in cycle 4+H+9*CLKS_PER_BIT: 79 for CLKS_PER_BIT=8. With parity, add CLKS_PER_BIT.
- Back-to-back frames from the transmitter (stop bit plus one-cycle gap) must be received with no loss. After the stop sample the receiver is in IDLE about half a bit before the next start edge.
- Reset asserted mid-frame: the block aborts immediately to reset values with no strobe. After release, the first start edge is received normally.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8E1: an even-parity bit follows data bit 7.
  - parity_err pulses with data_valid when the XOR of the 8 data bits and the parity bit is 1.
  - The byte is still delivered.
- UART_RX_PARITY_EN undefined:
  - No PARITY_BIT state; frame is 8N1.
  - parity_err is constant 0.
  - This is the mode that pairs with the existing transmitter.

## Structure
- Shared package uart_pkg holds:
  - State-encoding localparams shared by transmitter and receiver.
  - Default CLKS_PER_BIT.
  - DATA_BITS=8.
- One sub-module: uart_rx_sync. It is a two-flop synchronizer with reset value 1, is reusable, and is instantiated once here.

## Test plan
- Loopback with the transmitter, CLKS_PER_BIT=8, bytes 0x55, 0xA3, 0x00, 0xFF -> each byte on data_byte with data_valid at cycle 79 after the start edge; frame_err never asserts.
- Back-to-back transmitter frames 0x01 then 0x80 -> two data_valid pulses, correct bytes, no frame_err.
- Stop bit forced low, byte 0x3C -> frame_err pulse at cycle 79, data_byte keeps its previous value. Line then held low for 30 cycles -> no new reception until the line goes high.
- 2-cycle low glitch on an idle line -> return to IDLE via false start; no strobes; lineactive pulses high, then low.
- rst_n asserted during data bit 4 of 0xC7 -> all outputs 0 asynchronously. A following 0x5A is received correctly.
- With UART_RX_PARITY_EN, byte 0x07 sent with parity bit 0 -> data_valid plus parity_err. The same byte with parity bit 1 -> data_valid only.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   DATA_BITS        - payload bits per frame
//   CLKS_PER_BIT_DEF - default bit period in clk cycles
//   ST_*             - FSM state encodings shared by both directions
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // Counter value at the middle of a bit period.
    function automatic logic [7:0] half_bit(input int clks);
        return 8'((clks - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous level, reset to 1.
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic m;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, m} <= 2'b11;
        else        {q, m} <= {m, d};

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined).
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   uart_in    - serial line, idles high
//   data_byte  - last correctly framed byte
//   data_valid - one-cycle strobe, data_byte updated together
//   frame_err  - one-cycle strobe when the stop bit is low
//   parity_err - one-cycle strobe on parity mismatch (0 without UART_RX_PARITY_EN)
//   lineactive - high from start-bit detection to end of frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [7:0] data_byte,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       lineactive
);

    localparam logic [7:0] HALF = half_bit(CLKS_PER_BIT);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam int         IW   = $clog2(DATA_BITS);

    logic                 rx_s;
    logic [2:0]           state;
    logic [7:0]           cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bad;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (uart_in),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            data_byte  <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            lineactive <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state      <= ST_START;
                        lineactive <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                        end else begin
                            // glitch shorter than half a bit: not a real start
                            state      <= ST_IDLE;
                            lineactive <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        shift_reg[idx] <= rx_s;
                        idx            <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (idx == IW'(DATA_BITS - 1)) state <= ST_PARITY;
`else
                        if (idx == IW'(DATA_BITS - 1)) state <= ST_STOP;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bad <= ^shift_reg ^ rx_s;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        lineactive <= 1'b0;
                        if (rx_s) begin
                            data_byte  <= shift_reg;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state      <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // a break (held-low line) must not look like a new start bit
                ST_WAIT_HIGH: if (rx_s) state <= ST_IDLE;
                default: begin
                    state      <= ST_IDLE;
                    lineactive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a behavioural transmitter.
module tb_uart_rx;

    localparam int C = 8;
    localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int EXP_CYC = 4 + H + 9 * C + PB * C;

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        int         gap;
        int         exp_dv;
        int         exp_pe;
        logic [7:0] exp_byte;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_in = 1'b1;
    logic [7:0] data_byte;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       lineactive;

    int cyc = 0, start0 = 0;
    int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, la_cnt = 0;
    int dv_cyc = 0, fe_cyc = 0, overlap = 0, longp = 0;
    logic dv_d = 1'b0, fe_d = 1'b0;
    int errors = 0, checks = 0;
    int b_dv, b_fe, b_pe, b_la;
    logic [7:0] last_byte;
    vec_t vec[8];
    int nvec;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_in   (uart_in),
        .data_byte (data_byte),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .lineactive(lineactive)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc - start0;
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc - start0;
        end
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (lineactive) la_cnt = la_cnt + 1;
        if (data_valid && frame_err) overlap = overlap + 1;
        if ((data_valid && dv_d) || (frame_err && fe_d)) longp = longp + 1;
        dv_d = data_valid;
        fe_d = frame_err;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [7:0] d, input logic stop, input logic bad_par, input int gap);
        start0  = cyc;
        uart_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_in = ^d ^ bad_par;
        repeat (C) @(negedge clk);
`else
        if (bad_par) uart_in = 1'b1;
`endif
        uart_in = stop;
        repeat (C) @(negedge clk);
        if (gap > 0) begin
            uart_in = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic snap();
        b_dv = dv_cnt;
        b_fe = fe_cnt;
        b_pe = pe_cnt;
        b_la = la_cnt;
    endtask

    initial begin
        vec[0] = '{8'h55, 1'b0, 10, 1, 0, 8'h55};
        vec[1] = '{8'hA3, 1'b0, 10, 1, 0, 8'hA3};
        vec[2] = '{8'h00, 1'b0, 10, 1, 0, 8'h00};
        vec[3] = '{8'hFF, 1'b0, 10, 1, 0, 8'hFF};
        vec[4] = '{8'h01, 1'b0, 1,  1, 0, 8'h01};
        vec[5] = '{8'h80, 1'b0, 10, 1, 0, 8'h80};
        nvec = 6;
`ifdef UART_RX_PARITY_EN
        vec[6] = '{8'h07, 1'b1, 10, 1, 1, 8'h07};
        vec[7] = '{8'h07, 1'b0, 10, 1, 0, 8'h07};
        nvec = 8;
`else
        vec[6] = vec[5];
        vec[7] = vec[5];
`endif

        repeat (3) @(negedge clk);
        chk("rst_byte", int'(data_byte), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_perr", int'(parity_err), 0);
        chk("rst_active", int'(lineactive), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            snap();
            send(vec[i].d, 1'b1, vec[i].bad_par, vec[i].gap);
            chk($sformatf("v%0d_valid", i), dv_cnt - b_dv, vec[i].exp_dv);
            chk($sformatf("v%0d_cycle", i), dv_cyc, EXP_CYC);
            chk($sformatf("v%0d_byte", i), int'(data_byte), int'(vec[i].exp_byte));
            chk($sformatf("v%0d_ferr", i), fe_cnt - b_fe, 0);
            chk($sformatf("v%0d_perr", i), pe_cnt - b_pe, vec[i].exp_pe);
        end
        last_byte = vec[nvec-1].exp_byte;

        // low stop bit, then a 30-cycle break
        snap();
        send(8'h3C, 1'b0, 1'b0, 0);
        chk("fe_pulse", fe_cnt - b_fe, 1);
        chk("fe_cycle", fe_cyc, EXP_CYC);
        chk("fe_novalid", dv_cnt - b_dv, 0);
        chk("fe_byte_kept", int'(data_byte), int'(last_byte));
        snap();
        repeat (30) @(negedge clk);
        chk("break_active", la_cnt - b_la, 0);
        chk("break_strobes", dv_cnt - b_dv + fe_cnt - b_fe, 0);
        uart_in = 1'b1;
        repeat (5) @(negedge clk);
        snap();
        send(8'h96, 1'b1, 1'b0, 10);
        chk("after_break_valid", dv_cnt - b_dv, 1);
        chk("after_break_byte", int'(data_byte), 8'h96);

        // two-cycle glitch: lineactive high for edges 2..5 only
        snap();
        start0  = cyc;
        uart_in = 1'b0;
        repeat (2) @(negedge clk);
        uart_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_active_len", la_cnt - b_la, H + 1);
        chk("glitch_active_now", int'(lineactive), 0);
        chk("glitch_strobes", dv_cnt - b_dv + fe_cnt - b_fe, 0);

        // reset during data bit 4 of 0xC7
        snap();
        fork
            send(8'hC7, 1'b1, 1'b0, 10);
            begin
                repeat (8 + 4 * C + 4) @(negedge clk);
                chk("pre_rst_active", int'(lineactive), 1);
                rst_n = 1'b0;
                #1;
                chk("rst_mid_byte", int'(data_byte), 0);
                chk("rst_mid_active", int'(lineactive), 0);
                chk("rst_mid_valid", int'(data_valid), 0);
            end
        join
        chk("rst_mid_nostrobe", dv_cnt - b_dv + fe_cnt - b_fe, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        send(8'h5A, 1'b1, 1'b0, 10);
        chk("post_rst_valid", dv_cnt - b_dv, 1);
        chk("post_rst_cycle", dv_cyc, EXP_CYC);
        chk("post_rst_byte", int'(data_byte), 8'h5A);

        chk("valid_ferr_exclusive", overlap, 0);
        chk("single_cycle_strobes", longp, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
